itrx_aib_phy_bsr_ctl: RTL and testbench

- Boundary-scan register controller directly upstream of the AIB JTAG input/output boundary cells.
- Converts TAP-decoded DR/IR events into the per-cell controls `jtag_clkdr` enable, `jtag_scan_en` and `jtag_intest`.
- Drives the chain serial input and returns the chain serial output to the TAP.
- Tracks shifted-bit count so software can detect chain-length mismatch.

---
 rtl/itrx_aib_phy_jtag_pkg.sv | 19 +
 rtl/itrx_aib_phy_jtag_cg.sv | 19 +
 rtl/itrx_aib_phy_bsr_ctl.sv | 112 +++++++++++
 tb/tb_itrx_aib_phy_bsr_ctl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_jtag_pkg.sv
// Shared definitions for the AIB PHY JTAG boundary-scan logic: BSR controller
// state encoding and the default chain length.
package itrx_aib_phy_jtag_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CAPT  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] UPD   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StCapt  = CAPT,
        StShift = SHIFT,
        StUpd   = UPD
    } bsr_state_e;

    localparam int unsigned CHAIN_LEN_DEF = 96;

endpackage

// File: rtl/itrx_aib_phy_jtag_cg.sv
// Latch-based glitch-free clock gate producing jtag_clkdr from TCK.
module itrx_aib_phy_jtag_cg (
    input  logic clk,
    input  logic jtag_clkdr_en,
    output logic jtag_clkdr
);

    logic en_lat;

    // Enable only changes while TCK is low, so the gated high phase is never cut short.
    always_latch begin
        if (!clk) begin
            en_lat <= jtag_clkdr_en;
        end
    end

    assign jtag_clkdr = clk & en_lat;

endmodule

// File: rtl/itrx_aib_phy_bsr_ctl.sv
// Boundary-scan register controller for the AIB JTAG boundary cells.
// Optional shift-count length check enabled by `define ITRX_AIB_BSR_CNT_CHK_EN.
module itrx_aib_phy_bsr_ctl
    import itrx_aib_phy_jtag_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tap_tlr,
    input  logic             bsr_sel,
    input  logic             intest_ir,
    input  logic             tap_update_ir,
    input  logic             tap_capture_dr,
    input  logic             tap_shift_dr,
    input  logic             tap_update_dr,
    input  logic             tdi,
    input  logic             bsr_so,
    output logic             jtag_clkdr_en,
    output logic             jtag_scan_en,
    output logic             jtag_intest,
    output logic             bsr_si,
    output logic             tdo,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             cnt_err
);

    bsr_state_e state_q;
    logic       dr_live;
    logic       shift_act;
    logic       capt_act;

    // rst_n gates the decode so the cell controls drop with the asynchronous reset.
    assign dr_live   = rst_n & bsr_sel & ~tap_tlr & ~tap_update_dr;
    assign shift_act = dr_live & tap_shift_dr;
    assign capt_act  = dr_live & ~tap_shift_dr & tap_capture_dr;

    assign jtag_clkdr_en = shift_act | capt_act;
    assign jtag_scan_en  = shift_act;
    assign bsr_si        = shift_act & tdi;
    assign tdo           = bsr_sel & bsr_so;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            jtag_intest <= 1'b0;
        end else begin
            if (tap_tlr) begin
                jtag_intest <= 1'b0;
            end else if (tap_update_ir) begin
                jtag_intest <= intest_ir;
            end

            if (tap_tlr || !bsr_sel) begin
                state_q <= StIdle;
            end else if (tap_update_dr) begin
                state_q <= (state_q == StCapt || state_q == StShift) ? StUpd : StIdle;
            end else if (tap_shift_dr) begin
                if (state_q == StCapt) begin
                    state_q <= StShift;
                end else if (state_q == StUpd) begin
                    state_q <= StIdle;
                end
            end else if (tap_capture_dr) begin
                if (state_q == StIdle || state_q == StUpd) begin
                    state_q <= StCapt;
                end
            end else if (state_q == StUpd) begin
                state_q <= StIdle;
            end
        end
    end

`ifdef ITRX_AIB_BSR_CNT_CHK_EN
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(CHAIN_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (capt_act) begin
                cnt_q <= '0;
            end else if (shift_act && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Sticky: only TLR or rst_n clears a detected length mismatch.
            if (tap_tlr) begin
                err_q <= 1'b0;
            end else if (bsr_sel && tap_update_dr && cnt_q != CNT_GOOD &&
                         (state_q == StCapt || state_q == StShift)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign shift_cnt = cnt_q;
    assign cnt_err   = err_q;
`else
    logic unused_state;
    assign unused_state = ^state_q;
    assign shift_cnt    = '0;
    assign cnt_err      = 1'b0;
`endif

endmodule

// File: tb/tb_itrx_aib_phy_bsr_ctl.sv
// Self-checking bench for itrx_aib_phy_bsr_ctl: 96- and 200-cell chains share stimulus.
module tb_itrx_aib_phy_bsr_ctl;

`ifdef ITRX_AIB_BSR_CNT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, tap_tlr, bsr_sel, intest_ir, tap_update_ir;
    logic tap_capture_dr, tap_shift_dr, tap_update_dr, tdi, bsr_so;

    logic [1:0] o_en, o_scan, o_intest, o_si, o_tdo, o_err;
    logic [6:0] cnt96;
    logic [7:0] cnt200;
    logic       jtag_clkdr;

    int n_chk  = 0;
    int n_fail = 0;
    int clkdr_cnt = 0;

    // Behavioural model: per chain, bits shifted since capture, scan-open flag, sticky error.
    int m_cnt[2];
    bit m_err[2];
    bit m_open[2];
    bit m_intest;
    int m_len[2];
    int m_max[2];

    always #5 clk = ~clk;

    itrx_aib_phy_bsr_ctl #(.CHAIN_LEN(96)) u96 (
        .clk(clk), .rst_n(rst_n), .tap_tlr(tap_tlr), .bsr_sel(bsr_sel),
        .intest_ir(intest_ir), .tap_update_ir(tap_update_ir),
        .tap_capture_dr(tap_capture_dr), .tap_shift_dr(tap_shift_dr),
        .tap_update_dr(tap_update_dr), .tdi(tdi), .bsr_so(bsr_so),
        .jtag_clkdr_en(o_en[0]), .jtag_scan_en(o_scan[0]), .jtag_intest(o_intest[0]),
        .bsr_si(o_si[0]), .tdo(o_tdo[0]), .shift_cnt(cnt96), .cnt_err(o_err[0])
    );

    itrx_aib_phy_bsr_ctl #(.CHAIN_LEN(200)) u200 (
        .clk(clk), .rst_n(rst_n), .tap_tlr(tap_tlr), .bsr_sel(bsr_sel),
        .intest_ir(intest_ir), .tap_update_ir(tap_update_ir),
        .tap_capture_dr(tap_capture_dr), .tap_shift_dr(tap_shift_dr),
        .tap_update_dr(tap_update_dr), .tdi(tdi), .bsr_so(bsr_so),
        .jtag_clkdr_en(o_en[1]), .jtag_scan_en(o_scan[1]), .jtag_intest(o_intest[1]),
        .bsr_si(o_si[1]), .tdo(o_tdo[1]), .shift_cnt(cnt200), .cnt_err(o_err[1])
    );

    itrx_aib_phy_jtag_cg u_cg (
        .clk(clk), .jtag_clkdr_en(o_en[0]), .jtag_clkdr(jtag_clkdr)
    );

    always @(posedge jtag_clkdr) clkdr_cnt <= clkdr_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_intest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
            m_open[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (tap_tlr) m_intest = 1'b0;
            else if (tap_update_ir) m_intest = intest_ir;
            for (int k = 0; k < 2; k++) begin
                if (tap_tlr) begin
                    m_err[k] = 1'b0;
                    m_open[k] = 1'b0;
                end else if (!bsr_sel) begin
                    m_open[k] = 1'b0;
                end else if (tap_update_dr) begin
                    if (m_open[k] && m_cnt[k] != m_len[k]) m_err[k] = 1'b1;
                    m_open[k] = 1'b0;
                end else if (tap_shift_dr) begin
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                end else if (tap_capture_dr) begin
                    m_cnt[k] = 0;
                    m_open[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_comb();
        bit live, e_shift, e_capt;
        live    = rst_n && bsr_sel && !tap_tlr && !tap_update_dr;
        e_shift = live && tap_shift_dr;
        e_capt  = live && !tap_shift_dr && tap_capture_dr;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("clkdr_en[%0d]", k), int'(o_en[k]), int'(e_shift || e_capt));
            chk($sformatf("scan_en[%0d]", k), int'(o_scan[k]), int'(e_shift));
            chk($sformatf("bsr_si[%0d]", k), int'(o_si[k]), int'(e_shift && tdi));
            chk($sformatf("tdo[%0d]", k), int'(o_tdo[k]), int'(bsr_sel && bsr_so));
        end
    endtask

    task automatic check_reg();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("intest[%0d]", k), int'(o_intest[k]), int'(m_intest));
            chk($sformatf("cnt_err[%0d]", k), int'(o_err[k]), CHK ? int'(m_err[k]) : 0);
        end
        chk("shift_cnt96", int'(cnt96), CHK ? m_cnt[0] : 0);
        chk("shift_cnt200", int'(cnt200), CHK ? m_cnt[1] : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_reg();
    endtask

    task automatic set_idle();
        tap_tlr = 0; tap_update_ir = 0; tap_capture_dr = 0;
        tap_shift_dr = 0; tap_update_dr = 0; tdi = 0;
    endtask

    // Capture, n shifts of repeating 0xA5, update, one idle cycle.
    task automatic scan(input int n);
        logic [7:0] pat;
        int start;
        pat = 8'hA5;
        start = clkdr_cnt;
        set_idle();
        bsr_sel = 1;
        tap_capture_dr = 1;
        tick();
        tap_capture_dr = 0;
        for (int i = 0; i < n; i++) begin
            tap_shift_dr = 1;
            tdi = pat[7 - (i % 8)];
            tick();
        end
        set_idle();
        tap_update_dr = 1;
        tick();
        set_idle();
        tick();
        chk("clkdr_pulses", clkdr_cnt - start, n + 1);
    endtask

    typedef struct {
        logic tlr, sel, cap, sh, upd, tdi, so;
        logic en, scan, si, tdo;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0, 1, 0,  1, 1, 1, 0};
        tbl[2] = '{0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 1};
        tbl[3] = '{0, 1, 1, 1, 0, 1, 0,  1, 1, 1, 0};
        tbl[4] = '{0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 1};
        tbl[5] = '{0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0};
        tbl[6] = '{0, 1, 0, 0, 0, 1, 1,  0, 0, 0, 1};
        tbl[7] = '{1, 1, 0, 1, 0, 1, 0,  0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0};
        m_len = '{96, 200};
        m_max = '{(1 << $clog2(97)) - 1, (1 << $clog2(201)) - 1};

        // Reset with shift requested: decode must stay quiet.
        rst_n = 0; intest_ir = 0; bsr_so = 0;
        set_idle();
        bsr_sel = 1; tap_shift_dr = 1; tdi = 1;
        model_reset();
        #12;
        check_comb();
        check_reg();
        chk("rst_clkdr_en", int'(o_en[0]), 0);
        @(posedge clk); #1;
        set_idle();
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_clkdr_en", int'(o_en[0] | o_en[1]), 0);
        end

        foreach (tbl[i]) begin
            tap_tlr = tbl[i].tlr; bsr_sel = tbl[i].sel; tap_capture_dr = tbl[i].cap;
            tap_shift_dr = tbl[i].sh; tap_update_dr = tbl[i].upd;
            tdi = tbl[i].tdi; bsr_so = tbl[i].so;
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), int'(o_en[0]), int'(tbl[i].en));
            chk($sformatf("tbl%0d_scan", i), int'(o_scan[0]), int'(tbl[i].scan));
            chk($sformatf("tbl%0d_si", i), int'(o_si[0]), int'(tbl[i].si));
            chk($sformatf("tbl%0d_tdo", i), int'(o_tdo[1]), int'(tbl[i].tdo));
            @(posedge clk);
            model_step();
            #1;
            check_reg();
        end
        set_idle();
        bsr_so = 0;

        // INTEST load, unaffected by DR events, cleared by TLR.
        bsr_sel = 1; tap_update_ir = 1; intest_ir = 1;
        chk("intest_before", int'(o_intest[0]), 0);
        tick();
        chk("intest_set", int'(o_intest[0]), 1);
        set_idle();
        tap_capture_dr = 1;
        tick();
        chk("intest_dr_hold", int'(o_intest[0]), 1);
        set_idle();
        tap_tlr = 1;
        tick();
        chk("intest_tlr", int'(o_intest[0]), 0);
        set_idle();
        tap_update_ir = 1;
        tick();

        scan(96);
        chk("scan96_cnt", int'(cnt96), CHK ? 96 : 0);
        chk("scan96_err", int'(o_err[0]), 0);
        scan(95);
        chk("scan95_err", int'(o_err[0]), CHK ? 1 : 0);
        scan(96);
        chk("err_sticky", int'(o_err[0]), CHK ? 1 : 0);
        tap_tlr = 1;
        tick();
        chk("err_tlr_clr", int'(o_err[0]), 0);
        scan(200);
        chk("scan200_cnt", int'(cnt200), CHK ? 200 : 0);
        chk("scan200_err96", int'(o_err[0]), CHK ? 1 : 0);
        chk("scan200_err200", int'(o_err[1]), 0);
        scan(260);
        chk("sat127", int'(cnt96), CHK ? 127 : 0);
        chk("sat255", int'(cnt200), CHK ? 255 : 0);

        // Asynchronous reset in the middle of a shift.
        set_idle();
        bsr_sel = 1; tap_capture_dr = 1;
        tick();
        tap_capture_dr = 0;
        for (int i = 0; i < 40; i++) begin
            tap_shift_dr = 1;
            tdi = i[0];
            tick();
        end
        tdi = 1;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("arst_clkdr_en", int'(o_en[0] | o_en[1]), 0);
        chk("arst_scan_en", int'(o_scan[0] | o_scan[1]), 0);
        chk("arst_bsr_si", int'(o_si[0] | o_si[1]), 0);
        chk("arst_cnt", int'(cnt96) + int'(cnt200), 0);
        check_reg();
        chk("arst_clkdr_held", int'(jtag_clkdr), 1);
        @(negedge clk); #1;
        chk("arst_clkdr_low", int'(jtag_clkdr), 0);
        @(posedge clk); #1;
        chk("arst_clkdr_gated", int'(jtag_clkdr), 0);
        set_idle();
        rst_n = 1;
        tick();
        scan(96);
        chk("post_rst_cnt", int'(cnt96), CHK ? 96 : 0);
        chk("post_rst_err", int'(o_err[0]), 0);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            bsr_sel        = ($urandom_range(0, 7) != 0);
            tap_tlr        = ($urandom_range(0, 63) == 0);
            tap_update_ir  = ($urandom_range(0, 31) == 0);
            intest_ir      = 1'($urandom);
            tap_shift_dr   = (r < 9) || ($urandom_range(0, 15) == 0);
            tap_capture_dr = (r == 9 || r == 10) || ($urandom_range(0, 31) == 0);
            tap_update_dr  = (r == 11) || ($urandom_range(0, 63) == 0);
            tdi            = 1'($urandom);
            bsr_so         = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
